// File: rtl/glove_filter_if.sv
// Measurement-in / conditioned-glove-out bundle between the blob stage and the catch game.
interface glove_filter_if;
    logic        meas_valid;
    logic [10:0] meas_x;
    logic [9:0]  meas_y;
    logic [15:0] meas_area;
    logic [10:0] rel_x;
    logic [9:0]  rel_y;
    logic        closed;
    logic        can_catch;
    logic        track_valid;
    logic        sample_strobe;

    modport master (
        output meas_valid, meas_x, meas_y, meas_area,
        input  rel_x, rel_y, closed, can_catch, track_valid, sample_strobe
    );
    modport slave (
        input  meas_valid, meas_x, meas_y, meas_area,
        output rel_x, rel_y, closed, can_catch, track_valid, sample_strobe
    );
endinterface

// File: rtl/glove_filter.sv
// Per-glove conditioner: moving-average position, debounced open/closed state,
// catch readiness and frame-counted loss of track. Two-stage sample pipeline.
module glove_filter #(
    parameter int          AVG_LOG2       = 2,
    parameter logic [15:0] CLOSE_AREA     = 16'd1200,
    parameter logic [15:0] OPEN_AREA      = 16'd1800,
    parameter int          DEBOUNCE       = 3,
    parameter int          READY_FRAMES   = 4,
    parameter int          TIMEOUT_FRAMES = 8
) (
    input  logic          vclock,
    input  logic          reset,
    input  logic          vsync,
    glove_filter_if.slave gif
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SXW   = 11 + AVG_LOG2;
    localparam int SYW   = 10 + AVG_LOG2;
    localparam int DBW   = $clog2(DEBOUNCE + 1);
    localparam int RDW   = $clog2(READY_FRAMES + 1);
    localparam int TOW   = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [RDW-1:0] RD_MAX  = RDW'(READY_FRAMES);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(TIMEOUT_FRAMES);
    localparam logic [10:0]    HOME_X  = 11'd512;
    localparam logic [9:0]     HOME_Y  = 10'd384;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        vote_closed;
        logic        vote_open;
    } s1_t;

    logic [1:0]                 vld_pipe_q, vld_pipe_d;
    s1_t                        s1_q, s1_d;
    logic                       vsync_q, vsync_d;
    logic [TOW-1:0]             tmo_q, tmo_d;
    logic [DEPTH-1:0][10:0]     hist_x_q, hist_x_d;
    logic [DEPTH-1:0][9:0]      hist_y_q, hist_y_d;
    logic [AVG_LOG2-1:0]        wr_ptr_q, wr_ptr_d;
    logic [SXW-1:0]             sum_x_q, sum_x_d;
    logic [SYW-1:0]             sum_y_q, sum_y_d;
    logic [10:0]                rel_x_q, rel_x_d;
    logic [9:0]                 rel_y_q, rel_y_d;
    logic                       closed_q, closed_d;
    logic [DBW-1:0]             db_q, db_d;
    logic [RDW-1:0]             ready_q, ready_d;
    logic                       track_q, track_d;
    logic                       can_q, can_d;
    logic                       frame_fall, agreeing, opposing;

    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], gif.meas_valid};
        vsync_d    = vsync;
        frame_fall = vsync_q & ~vsync;
        s1_d       = s1_q;
        if (gif.meas_valid) begin
            s1_d = '{x: gif.meas_x, y: gif.meas_y,
                     vote_closed: gif.meas_area <= CLOSE_AREA,
                     vote_open:   gif.meas_area >= OPEN_AREA};
        end

        // A measurement in the same cycle as a frame edge keeps the track alive.
        tmo_d = tmo_q;
        if (gif.meas_valid)                   tmo_d = '0;
        else if (frame_fall && tmo_q != TO_MAX) tmo_d = tmo_q + TOW'(1);

        hist_x_d = hist_x_q;
        hist_y_d = hist_y_q;
        wr_ptr_d = wr_ptr_q;
        sum_x_d  = sum_x_q;
        sum_y_d  = sum_y_q;
        rel_x_d  = rel_x_q;
        rel_y_d  = rel_y_q;
        closed_d = closed_q;
        db_d     = db_q;
        ready_d  = ready_q;
        track_d  = track_q;
        agreeing = closed_q ? s1_q.vote_closed : s1_q.vote_open;
        opposing = closed_q ? s1_q.vote_open   : s1_q.vote_closed;

        if (vld_pipe_q[0]) begin
            // Re-acquisition fills the window so the output jumps instead of slewing.
            if (!track_q) begin
                hist_x_d = {DEPTH{s1_q.x}};
                hist_y_d = {DEPTH{s1_q.y}};
                sum_x_d  = {s1_q.x, {AVG_LOG2{1'b0}}};
                sum_y_d  = {s1_q.y, {AVG_LOG2{1'b0}}};
            end else begin
                sum_x_d  = sum_x_q + SXW'(s1_q.x) - SXW'(hist_x_q[wr_ptr_q]);
                sum_y_d  = sum_y_q + SYW'(s1_q.y) - SYW'(hist_y_q[wr_ptr_q]);
                hist_x_d[wr_ptr_q] = s1_q.x;
                hist_y_d[wr_ptr_q] = s1_q.y;
            end
            wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
            rel_x_d  = sum_x_d[SXW-1:AVG_LOG2];
            rel_y_d  = sum_y_d[SYW-1:AVG_LOG2];

            if (agreeing) begin
                db_d = '0;
            end else if (opposing) begin
                if (db_q == DB_LAST) begin
                    closed_d = ~closed_q;
                    db_d     = '0;
                end else begin
                    db_d = db_q + DBW'(1);
                end
            end

            if (closed_d)                                ready_d = '0;
            else if (s1_q.vote_open && ready_q != RD_MAX) ready_d = ready_q + RDW'(1);
            track_d = 1'b1;
        end

        if (tmo_d == TO_MAX) begin
            track_d = 1'b0;
            ready_d = '0;
        end
        can_d = track_d && (ready_d == RD_MAX);
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            vsync_q    <= 1'b1;
            tmo_q      <= '0;
            hist_x_q   <= {DEPTH{HOME_X}};
            hist_y_q   <= {DEPTH{HOME_Y}};
            wr_ptr_q   <= '0;
            sum_x_q    <= {HOME_X, {AVG_LOG2{1'b0}}};
            sum_y_q    <= {HOME_Y, {AVG_LOG2{1'b0}}};
            rel_x_q    <= HOME_X;
            rel_y_q    <= HOME_Y;
            closed_q   <= 1'b0;
            db_q       <= '0;
            ready_q    <= '0;
            track_q    <= 1'b0;
            can_q      <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            vsync_q    <= vsync_d;
            tmo_q      <= tmo_d;
            hist_x_q   <= hist_x_d;
            hist_y_q   <= hist_y_d;
            wr_ptr_q   <= wr_ptr_d;
            sum_x_q    <= sum_x_d;
            sum_y_q    <= sum_y_d;
            rel_x_q    <= rel_x_d;
            rel_y_q    <= rel_y_d;
            closed_q   <= closed_d;
            db_q       <= db_d;
            ready_q    <= ready_d;
            track_q    <= track_d;
            can_q      <= can_d;
        end
    end

    assign gif.rel_x         = rel_x_q;
    assign gif.rel_y         = rel_y_q;
    assign gif.closed        = closed_q;
    assign gif.can_catch     = can_q;
    assign gif.track_valid   = track_q;
    assign gif.sample_strobe = vld_pipe_q[1];
endmodule

// File: tb/tb_glove_filter.sv
// Random and directed stimulus for glove_filter, compared every cycle against a
// sample-level model (window queue average, vote streaks, frame counting).
module tb_glove_filter;
    logic vclock = 1'b0;
    logic reset  = 1'b1;
    logic vsync  = 1'b1;

    glove_filter_if gif ();
    glove_filter dut (.vclock(vclock), .reset(reset), .vsync(vsync), .gif(gif));

    always #5 vclock = ~vclock;

    typedef struct {
        int x;
        int y;
        bit closed;
        bit can;
        bit track;
    } out_t;

    out_t cur;
    out_t expq[$];
    int   win_x[$];
    int   win_y[$];
    bit   m_closed, m_tracked;
    int   m_streak, m_ready, m_tmo;
    bit   pipe1, pipe2, vs_prev;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        win_x.delete(); win_y.delete();
        m_closed = 0; m_tracked = 0; m_streak = 0; m_ready = 0; m_tmo = 0;
        cur = '{x: 512, y: 384, closed: 0, can: 0, track: 0};
    endfunction

    function automatic out_t m_sample(int x, int y, int a);
        out_t o;
        int sx = 0, sy = 0;
        bit vc = (a <= 1200);
        bit vo = (a >= 1800);
        m_tmo = 0;
        if (!m_tracked) begin
            win_x.delete(); win_y.delete();
            repeat (4) begin win_x.push_back(x); win_y.push_back(y); end
        end else begin
            win_x.push_back(x); win_y.push_back(y);
            void'(win_x.pop_front()); void'(win_y.pop_front());
        end
        foreach (win_x[i]) begin sx += win_x[i]; sy += win_y[i]; end
        // Streak of votes for the other state since the last vote for the current one.
        if ((m_closed && vc) || (!m_closed && vo)) m_streak = 0;
        else if ((m_closed && vo) || (!m_closed && vc)) begin
            m_streak++;
            if (m_streak == 3) begin m_closed = !m_closed; m_streak = 0; end
        end
        if (m_closed) m_ready = 0;
        else if (vo && m_ready < 4) m_ready++;
        m_tracked = 1;
        o = '{x: sx / 4, y: sy / 4, closed: m_closed, can: (m_ready == 4), track: 1};
        return o;
    endfunction

    function automatic void m_frame();
        if (m_tmo < 8) m_tmo++;
        if (m_tmo == 8) begin
            m_tracked = 0; m_ready = 0; cur.track = 0; cur.can = 0;
        end
    endfunction

    task automatic cyc(input bit v, input int x, input int y, input int a, input bit vs);
        gif.meas_valid = v;
        gif.meas_x     = 11'(x);
        gif.meas_y     = 10'(y);
        gif.meas_area  = 16'(a);
        vsync          = vs;
        if (!reset) begin
            if (v) expq.push_back(m_sample(x, y, a));
            else if (vs_prev && !vs) m_frame();
        end
        vs_prev = vs;
        @(posedge vclock); #1;
        pipe2 = pipe1;
        pipe1 = v && !reset;
        if (reset) begin
            pipe1 = 0; pipe2 = 0; expq.delete(); m_reset();
        end
        chk("sample_strobe", 32'(gif.sample_strobe), 32'(pipe2));
        if (pipe2) begin
            if (expq.size() > 0) cur = expq.pop_front();
            else chk("expect_queue", 32'(expq.size()), 32'd1);
        end
        chk("rel_x", 32'(gif.rel_x), 32'(cur.x));
        chk("rel_y", 32'(gif.rel_y), 32'(cur.y));
        chk("closed", 32'(gif.closed), 32'(cur.closed));
        chk("can_catch", 32'(gif.can_catch), 32'(cur.can));
        chk("track_valid", 32'(gif.track_valid), 32'(cur.track));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic send(input int x, input int y, input int a);
        cyc(1, x, y, a, 1);
        idle(); idle();
    endtask

    task automatic frames(input int n);
        repeat (n) begin cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1); end
    endtask

    function automatic int rand_area();
        case ($urandom_range(0, 4))
            0: return $urandom_range(0, 1199);
            1: return 1200;
            2: return $urandom_range(1201, 1799);
            3: return 1800;
            default: return $urandom_range(1801, 4000);
        endcase
    endfunction

    initial begin
        gif.meas_valid = 0; gif.meas_x = 0; gif.meas_y = 0; gif.meas_area = 0;
        vs_prev = 1; pipe1 = 0; pipe2 = 0;
        m_reset();
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        reset = 0;
        idle();

        send(600, 400, 2000);
        send(600, 400, 2000); send(600, 400, 2000); send(600, 400, 2000);
        send(700, 400, 2000);
        chk("avg_625", 32'(gif.rel_x), 32'd625);
        send(700, 400, 2000); send(700, 400, 2000); send(700, 400, 2000);
        chk("avg_700", 32'(gif.rel_x), 32'd700);

        send(700, 400, 1000); send(700, 400, 1000); send(700, 400, 1500);
        chk("none_holds", 32'(gif.closed), 32'd0);
        send(700, 400, 1000);
        chk("third_close", 32'(gif.closed), 32'd1);

        send(700, 400, 2000); send(700, 400, 2000); send(700, 400, 2000);
        send(700, 400, 1000); send(700, 400, 2000); send(700, 400, 1000); send(700, 400, 2000);
        chk("alternating", 32'(gif.closed), 32'd0);

        send(650, 350, 2000); send(650, 350, 2000); send(650, 350, 2000);
        send(650, 350, 1000); send(650, 350, 1000); send(650, 350, 1000);
        chk("close_drops_catch", 32'(gif.can_catch), 32'd0);

        send(640, 360, 2000); send(640, 360, 2000); send(640, 360, 2000); send(640, 360, 2000);
        frames(8);
        chk("timeout_track", 32'(gif.track_valid), 32'd0);
        send(300, 200, 2000);
        chk("reacquire_x", 32'(gif.rel_x), 32'd300);

        frames(7);
        cyc(1, 310, 210, 2000, 0);
        cyc(0, 0, 0, 0, 1); idle(); idle();
        frames(7);
        chk("coincident_clear", 32'(gif.track_valid), 32'd1);

        for (int i = 0; i < 4; i++) cyc(1, 100 + 50 * i, 100 + 40 * i, 2000, 1);
        idle(); idle();

        cyc(1, 900, 700, 2000, 1);
        reset = 1;
        idle(); idle();
        reset = 0;
        idle();

        for (int it = 0; it < 250; it++) begin
            int op = $urandom_range(0, 10);
            if (op <= 5) begin
                send($urandom_range(0, 1023), $urandom_range(0, 767), rand_area());
            end else if (op <= 7) begin
                int n = $urandom_range(2, 4);
                for (int k = 0; k < n; k++)
                    cyc(1, $urandom_range(0, 1023), $urandom_range(0, 767), rand_area(), 1);
                idle(); idle();
            end else if (op <= 9) begin
                frames($urandom_range(1, 4));
            end else begin
                frames(9);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
